// File: rtl/spi_sched_pkg.sv
// Shared types and width helpers for the SPI job scheduler and its arbiter.
package spi_sched_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_e;

  localparam int unsigned DEF_N_JOBS     = 4;
  localparam int unsigned DEF_GAP_CYCLES = 8;
  localparam int unsigned DEF_TIMEOUT    = 2_700_000;

  // Width of a down-counter that must hold max_val; never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_job_scheduler_if.sv
// Engine-side and link-side signals of the SPI job scheduler.
interface spi_job_scheduler_if #(
  parameter int unsigned N_JOBS = 4
);
  localparam int unsigned IDX_W = $clog2(N_JOBS);

  logic [N_JOBS-1:0] i_req;
  logic [N_JOBS-1:0] i_done;
  logic [N_JOBS-1:0] i_mosi;
  logic [N_JOBS-1:0] i_dc;
  logic [N_JOBS-1:0] i_cs;
  logic [N_JOBS-1:0] o_start;
  logic [N_JOBS-1:0] o_grant;
  logic              o_mosi;
  logic              o_dc;
  logic              o_cs;
  logic              o_busy;
  logic              o_timeout;
  logic [IDX_W-1:0]  o_err_id;

  // Scheduler side
  modport master (
    input  i_req, i_done, i_mosi, i_dc, i_cs,
    output o_start, o_grant, o_mosi, o_dc, o_cs, o_busy, o_timeout, o_err_id
  );

  // Engines and link side
  modport slave (
    output i_req, i_done, i_mosi, i_dc, i_cs,
    input  o_start, o_grant, o_mosi, o_dc, o_cs, o_busy, o_timeout, o_err_id
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request after i_last_idx,
// wrapping around.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] k;

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    k       = '0;
    // Walk farthest offset first so the nearest set bit after last_idx wins.
    for (int i = N; i >= 1; i--) begin
      k = IDX_W'((32'(i_last_idx) + 32'(i)) % N);
      if (i_req[k]) o_idx = k;
    end
  end

endmodule

// File: rtl/spi_job_scheduler.sv
// Round-robin scheduler sharing one SPI display link between several drawing engines,
// with a CS-high gap between jobs and a per-job watchdog.
module spi_job_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned N_JOBS     = DEF_N_JOBS,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  spi_job_scheduler_if.master bus
);

  localparam int unsigned IDX_W    = idx_w(N_JOBS);
  localparam int unsigned WD_W     = cnt_w(TIMEOUT);
  localparam int unsigned GAP_W    = cnt_w(GAP_CYCLES);
  localparam int unsigned GAP_LOAD = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             job_end;
  logic             timeout;
  logic             held;

  rr_pick #(
    .N     (N_JOBS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req      (bus.i_req),
    .i_last_idx (last_q),
    .o_valid    (pick_valid),
    .o_idx      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    err_d   = err_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    job_end = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          state_d = START;
        end
      end
      START: begin
        wd_d    = WD_W'(TIMEOUT);
        state_d = RUN;
      end
      RUN: begin
        wd_d = wd_q - WD_W'(1);
        // Done takes priority over a watchdog expiring in the same cycle.
        if (bus.i_done[idx_q]) begin
          job_end = 1'b1;
        end else if (wd_q == WD_W'(1)) begin
          job_end = 1'b1;
          timeout = 1'b1;
          err_d   = idx_q;
        end
        if (job_end) begin
          last_d  = idx_q;
          gap_d   = GAP_W'(GAP_LOAD);
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_JOBS - 1);
      err_q   <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign held = (state_q == START) || (state_q == RUN);

  always_comb begin
    bus.o_grant = '0;
    bus.o_start = '0;
    bus.o_mosi  = 1'b0;
    bus.o_dc    = 1'b0;
    bus.o_cs    = 1'b1;
    if (held) begin
      bus.o_grant[idx_q] = 1'b1;
      bus.o_mosi         = bus.i_mosi[idx_q];
      bus.o_dc           = bus.i_dc[idx_q];
      bus.o_cs           = bus.i_cs[idx_q];
    end
    if (state_q == START) bus.o_start[idx_q] = 1'b1;
  end

  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_timeout = timeout;
  assign bus.o_err_id  = err_q;

endmodule

// File: tb/tb_spi_job_scheduler.sv
// Directed bench: two scheduler instances (GAP 8 and GAP 0, both with TIMEOUT 100).
module tb_spi_job_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  spi_job_scheduler_if #(.N_JOBS(N)) ifa ();
  spi_job_scheduler_if #(.N_JOBS(N)) ifb ();

  spi_job_scheduler #(.N_JOBS(N), .GAP_CYCLES(8), .TIMEOUT(TMO)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifa)
  );

  spi_job_scheduler #(.N_JOBS(N), .GAP_CYCLES(0), .TIMEOUT(TMO)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string name, input int budget, output logic [3:0] g);
    g = 4'b0000;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (ifa.o_start != 4'b0000) begin
        g = ifa.o_start;
        break;
      end
    end
    if (g == 4'b0000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no start pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (ifa.o_busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: busy still %b, required 0", name, ifa.o_busy);
    end
  endtask

  task automatic test_reset;
    ifa.i_mosi = 4'hF; ifa.i_dc = 4'hF; ifa.i_cs = 4'h0;
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({ifa.o_grant, ifa.o_start, ifa.o_busy, ifa.o_timeout} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: grant=%b start=%b busy=%b to=%b, required all 0",
               ifa.o_grant, ifa.o_start, ifa.o_busy, ifa.o_timeout);
    end
    n_checks++;
    if (ifa.o_err_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_err_id: got %0d required 0", ifa.o_err_id);
    end
    n_checks++;
    if ({ifa.o_mosi, ifa.o_dc, ifa.o_cs} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_link: mosi/dc/cs=%b required 001", {ifa.o_mosi, ifa.o_dc, ifa.o_cs});
    end
    n_checks++;
    if ({ifb.o_busy, ifb.o_cs, ifb.o_grant} !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_b: busy=%b cs=%b grant=%b required 0,1,0000",
               ifb.o_busy, ifb.o_cs, ifb.o_grant);
    end
    ifa.i_mosi = 4'h0; ifa.i_dc = 4'h0; ifa.i_cs = 4'hF;
    rst = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ifa.i_req = '0; ifa.i_done = '0;
    ifb.i_req = '0; ifb.i_done = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic bad;
    ifa.i_req = 4'b0001;
    tick();  // start cycle s
    n_checks++;
    if (ifa.o_grant !== 4'b0001 || ifa.o_start !== 4'b0001 || ifa.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_start: grant=%b start=%b busy=%b required 0001 0001 1",
               ifa.o_grant, ifa.o_start, ifa.o_busy);
    end
    ifa.i_req = 4'b0000;
    tick();  // s+1
    n_checks++;
    if (ifa.o_start !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_start_pulse: start=%b in cycle after start, required 0000", ifa.o_start);
    end
    ifa.i_mosi[0] = 1'b1; ifa.i_dc[0] = 1'b1; ifa.i_cs[0] = 1'b0;
    #1;
    n_checks++;
    if ({ifa.o_mosi, ifa.o_dc, ifa.o_cs} !== 3'b110) begin
      n_fail++;
      $display("FAIL single_link: mosi/dc/cs=%b required 110", {ifa.o_mosi, ifa.o_dc, ifa.o_cs});
    end
    ifa.i_mosi[0] = 1'b0;
    #1;
    n_checks++;
    if (ifa.o_mosi !== 1'b0) begin
      n_fail++;
      $display("FAIL single_link_mosi: mosi=%b required 0", ifa.o_mosi);
    end
    bad = 1'b0;
    repeat (49) begin
      tick();
      if (ifa.o_grant !== 4'b0001 || ifa.o_cs !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL single_hold: grant/cs lost before done, got grant=%b cs=%b",
               ifa.o_grant, ifa.o_cs);
    end
    ifa.i_done[0] = 1'b1;  // s+50
    tick();
    ifa.i_done = '0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ifa.o_cs !== 1'b1 || ifa.o_grant !== 4'b0000 || ifa.o_busy !== 1'b1) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL single_gap: gap cycles not cs=1/grant=0/busy=1");
    end
    n_checks++;
    if (ifa.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap_end: busy=%b after 8 gap cycles, required 0", ifa.o_busy);
    end
    ifa.i_mosi = 4'h0; ifa.i_dc = 4'h0; ifa.i_cs = 4'hF;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rr [6];
    logic [3:0] g;
    exp_rr = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    do_reset();
    ifa.i_req = 4'b1011;
    for (int j = 0; j < 6; j++) begin
      wait_start("rr_wait", 40, g);
      n_checks++;
      if (g !== exp_rr[j]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: granted %b required %b", j, g, exp_rr[j]);
      end
      repeat (10) tick();
      ifa.i_done = g;
      if (j == 5) ifa.i_req = 4'b0000;
      tick();
      ifa.i_done = '0;
    end
    wait_idle("rr_idle");
  endtask

  task automatic test_timeout;
    logic [3:0] g;
    logic       early;
    ifa.i_req = 4'b1100;
    wait_start("to_wait", 5, g);
    n_checks++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("FAIL to_grant: granted %b required 0100", g);
    end
    early = 1'b0;
    repeat (99) begin
      tick();
      if (ifa.o_timeout !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL to_early: timeout pulsed before 100 cycles");
    end
    tick();  // s+100
    n_checks++;
    if (ifa.o_timeout !== 1'b1 || ifa.o_grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL to_pulse: timeout=%b grant=%b at start+100, required 1 0100",
               ifa.o_timeout, ifa.o_grant);
    end
    ifa.i_req = 4'b1000;
    tick();
    n_checks++;
    if (ifa.o_timeout !== 1'b0 || ifa.o_err_id !== 2'd2 || ifa.o_grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_after: timeout=%b err_id=%0d grant=%b, required 0 2 0000",
               ifa.o_timeout, ifa.o_err_id, ifa.o_grant);
    end
    wait_start("to_next_wait", 20, g);
    n_checks++;
    if (g !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_next: granted %b required 1000", g);
    end
    ifa.i_req = 4'b0000;
    tick();
    ifa.i_done = 4'b1000;
    tick();
    ifa.i_done = '0;
    wait_idle("to_idle");
  endtask

  task automatic test_done_at_expiry;
    logic [3:0] g;
    ifa.i_req = 4'b0001;
    wait_start("tie_wait", 5, g);
    ifa.i_req = 4'b0000;
    repeat (100) tick();  // s+100, watchdog on its last cycle
    ifa.i_done[0] = 1'b1;
    #1;
    n_checks++;
    if (ifa.o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_timeout: timeout=%b with done on expiry, required 0", ifa.o_timeout);
    end
    tick();
    ifa.i_done = '0;
    n_checks++;
    if (ifa.o_busy !== 1'b1 || ifa.o_grant !== 4'b0000 || ifa.o_cs !== 1'b1 ||
        ifa.o_timeout !== 1'b0 || ifa.o_err_id !== 2'd2) begin
      n_fail++;
      $display("FAIL tie_gap: busy=%b grant=%b cs=%b to=%b err=%0d, required 1 0000 1 0 2",
               ifa.o_busy, ifa.o_grant, ifa.o_cs, ifa.o_timeout, ifa.o_err_id);
    end
    wait_idle("tie_idle");
  endtask

  task automatic test_reset_mid_run;
    logic [3:0] g;
    ifa.i_req = 4'b0010;
    wait_start("rst_w1", 5, g);
    ifa.i_req = 4'b0000;
    tick();
    ifa.i_done = 4'b0010;
    tick();
    ifa.i_done = '0;
    wait_idle("rst_idle1");
    ifa.i_req = 4'b1000;
    wait_start("rst_w3", 5, g);
    n_checks++;
    if (g !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_pre_grant: granted %b required 1000", g);
    end
    ifa.i_req = 4'b0000;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (ifa.o_grant !== 4'b0000 || ifa.o_cs !== 1'b1 || ifa.o_busy !== 1'b0 ||
        ifa.o_start !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid: grant=%b cs=%b busy=%b start=%b, required 0000 1 0 0000",
               ifa.o_grant, ifa.o_cs, ifa.o_busy, ifa.o_start);
    end
    rst = 1'b0;
    ifa.i_req = 4'b1110;
    tick();
    n_checks++;
    if (ifa.o_start !== 4'b0010 || ifa.o_grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_regrant: start=%b grant=%b, required 0010 0010",
               ifa.o_start, ifa.o_grant);
    end
    ifa.i_req = 4'b0000;
    tick();
    ifa.i_done = 4'b0010;
    tick();
    ifa.i_done = '0;
    wait_idle("rst_idle2");
  endtask

  task automatic test_gap_zero;
    do_reset();
    ifb.i_req = 4'b0011;
    tick();  // s
    n_checks++;
    if (ifb.o_start !== 4'b0001 || ifb.o_grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL g0_start0: start=%b grant=%b required 0001 0001", ifb.o_start, ifb.o_grant);
    end
    tick();  // s+1
    ifb.i_done = 4'b0010;  // non-granted engine
    tick();  // s+2
    ifb.i_done = 4'b0000;
    n_checks++;
    if (ifb.o_grant !== 4'b0001 || ifb.o_busy !== 1'b1 || ifb.o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL g0_foreign_done: grant=%b busy=%b to=%b required 0001 1 0",
               ifb.o_grant, ifb.o_busy, ifb.o_timeout);
    end
    ifb.i_done = 4'b0001;
    tick();  // s+3
    ifb.i_done = 4'b0000;
    n_checks++;
    if (ifb.o_grant !== 4'b0000 || ifb.o_cs !== 1'b1 || ifb.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL g0_idle: grant=%b cs=%b busy=%b required 0000 1 0",
               ifb.o_grant, ifb.o_cs, ifb.o_busy);
    end
    tick();  // s+4
    n_checks++;
    if (ifb.o_start !== 4'b0010 || ifb.o_grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL g0_start1: start=%b grant=%b required 0010 0010", ifb.o_start, ifb.o_grant);
    end
    ifb.i_req = 4'b0000;
    tick();
    ifb.i_done = 4'b0010;
    tick();
    ifb.i_done = 4'b0000;
    n_checks++;
    if (ifb.o_busy !== 1'b0 || ifb.o_grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL g0_end: busy=%b grant=%b required 0 0000", ifb.o_busy, ifb.o_grant);
    end
  endtask

  initial begin
    ifa.i_req = '0; ifa.i_done = '0; ifa.i_mosi = '0; ifa.i_dc = '0; ifa.i_cs = '1;
    ifb.i_req = '0; ifb.i_done = '0; ifb.i_mosi = '0; ifb.i_dc = '0; ifb.i_cs = '1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_expiry();
    test_reset_mid_run();
    test_gap_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

endmodule
